// File: rtl/in_register_dbuf_if.sv
// Write/output bundle for in_register_dbuf: chunk write port, fill index and held
// output vector with its valid/ack handshake.
interface in_register_dbuf_if #(
  parameter int C_NUM_BITS  = 72,
  parameter int C_BUS_WIDTH = 32
);
  localparam int C_NUM_WORDS  = (C_NUM_BITS + C_BUS_WIDTH - 1) / C_BUS_WIDTH;
  localparam int C_COUNT_BITS = (C_NUM_WORDS > 1) ? $clog2(C_NUM_WORDS) : 1;

  logic [C_BUS_WIDTH-1:0]  din;
  logic                    we;
  logic                    din_ready;
  logic                    flush;
  logic [C_COUNT_BITS-1:0] word_idx;
  logic [C_NUM_BITS-1:0]   dout;
  logic                    dout_valid;
  logic                    dout_ack;

  modport master (
    output din, we, flush, dout_ack,
    input  din_ready, word_idx, dout, dout_valid
  );

  modport slave (
    input  din, we, flush, dout_ack,
    output din_ready, word_idx, dout, dout_valid
  );
endinterface

// File: rtl/in_register_dbuf.sv
// Double-buffered input register: assembles C_NUM_BITS from C_BUS_WIDTH chunks and holds
// the result under a valid/ack handshake. Optional sticky overrun flag: IN_REGISTER_DBUF_OVERRUN_EN.
module in_register_dbuf #(
  parameter int C_NUM_BITS  = 72,
  parameter int C_BUS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  in_register_dbuf_if.slave   bus
`ifdef IN_REGISTER_DBUF_OVERRUN_EN
  ,
  output logic                overrun
`endif
);

  localparam int C_NUM_WORDS  = (C_NUM_BITS + C_BUS_WIDTH - 1) / C_BUS_WIDTH;
  localparam int C_COUNT_BITS = (C_NUM_WORDS > 1) ? $clog2(C_NUM_WORDS) : 1;
  localparam logic [C_COUNT_BITS-1:0] C_LAST_IDX = C_COUNT_BITS'(C_NUM_WORDS - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [C_COUNT_BITS-1:0] word_idx_q, word_idx_d;
  // Bits of the last chunk above C_NUM_BITS can never reach dout, so they are not stored.
  logic [C_NUM_BITS-1:0]   buf_q, buf_d;
  logic [C_NUM_BITS-1:0]   dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic [C_NUM_BITS-1:0]   wr_vec;
  logic                    din_ready;
  logic                    accept;
  logic                    last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      word_idx_q   <= '0;
      buf_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      buf_q        <= buf_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    buf_d        = buf_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    din_ready = (state_q == FILL);
    accept    = bus.we && din_ready && !bus.flush;
    last_word = (word_idx_q == C_LAST_IDX);

    // Buffer with the incoming chunk merged at word_idx; on the last word this is the full vector.
    wr_vec = buf_q;
    for (int b = 0; b < C_NUM_BITS; b++) begin
      if (C_COUNT_BITS'(b / C_BUS_WIDTH) == word_idx_q) begin
        wr_vec[b] = bus.din[b % C_BUS_WIDTH];
      end
    end

    case (state_q)
      FILL: begin
        if (bus.dout_ack && dout_valid_q) begin
          dout_valid_d = 1'b0;
        end
        if (bus.flush) begin
          word_idx_d = '0;
        end else if (accept) begin
          if (!last_word) begin
            buf_d      = wr_vec;
            word_idx_d = word_idx_q + C_COUNT_BITS'(1);
          end else begin
            word_idx_d = '0;
            if (!dout_valid_q || bus.dout_ack) begin
              dout_d       = wr_vec;
              dout_valid_d = 1'b1;
            end else begin
              buf_d   = wr_vec;
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (bus.dout_ack) begin
          dout_d       = buf_q;
          dout_valid_d = 1'b1;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.din_ready  = din_ready;
  assign bus.word_idx   = word_idx_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

`ifdef IN_REGISTER_DBUF_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    overrun_d = overrun_q | (bus.we && !din_ready);
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_in_register_dbuf.sv
// Self-checking bench for in_register_dbuf: scoreboard of expected vectors on the 72/32
// instance plus direct checks, and a 16/64 single-word instance.
module tb_in_register_dbuf;

  logic clk;
  logic rst;

  int checks;
  int failures;

  logic [127:0] sb_q[$];
  logic         prev_valid;
  logic [71:0]  prev_dout;

  in_register_dbuf_if #(.C_NUM_BITS(72), .C_BUS_WIDTH(32)) bus ();
  in_register_dbuf_if #(.C_NUM_BITS(16), .C_BUS_WIDTH(64)) bus2 ();

`ifdef IN_REGISTER_DBUF_OVERRUN_EN
  logic overrun;
  logic overrun2;
`endif

  in_register_dbuf #(.C_NUM_BITS(72), .C_BUS_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave)
`ifdef IN_REGISTER_DBUF_OVERRUN_EN
    ,
    .overrun (overrun)
`endif
  );

  in_register_dbuf #(.C_NUM_BITS(16), .C_BUS_WIDTH(64)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2.slave)
`ifdef IN_REGISTER_DBUF_OVERRUN_EN
    ,
    .overrun (overrun2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  // One cycle of stimulus on the 72/32 instance; returns just after the sampling edge.
  task automatic applyStimulus(input logic [31:0] d, input logic w, input logic f, input logic a);
    @(negedge clk);
    bus.din      = d;
    bus.we       = w;
    bus.flush    = f;
    bus.dout_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusWide(input logic [63:0] d, input logic w, input logic a);
    @(negedge clk);
    bus2.din      = d;
    bus2.we       = w;
    bus2.flush    = 1'b0;
    bus2.dout_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst           = 1'b1;
    bus.we        = 1'b0;
    bus.flush     = 1'b0;
    bus.dout_ack  = 1'b0;
    bus2.we       = 1'b0;
    bus2.flush    = 1'b0;
    bus2.dout_ack = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // A new vector is presented when valid rises or dout changes while valid stays high.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dout_valid && (!prev_valid || bus.dout != prev_dout)) begin
        logic [127:0] exp_vec;
        exp_vec = 'x;
        if (sb_q.size() > 0) exp_vec = sb_q.pop_front();
        checkOutput("sb_dout", 128'(bus.dout), exp_vec);
      end
    end
    prev_valid = bus.dout_valid;
    prev_dout  = bus.dout;
  end

  initial begin
    checks        = 0;
    failures      = 0;
    prev_valid    = 1'b0;
    prev_dout     = '0;
    rst           = 1'b1;
    bus.din       = '0;
    bus2.din      = '0;
    applyReset();

    // Reset state
    checkOutput("rst_din_ready", 128'(bus.din_ready), 128'(1));
    checkOutput("rst_word_idx", 128'(bus.word_idx), 128'(0));
    checkOutput("rst_dout_valid", 128'(bus.dout_valid), 128'(0));
    checkOutput("rst_dout", 128'(bus.dout), 128'(0));

    // Vector A: three consecutive writes, upper bits of the last chunk dropped
    applyStimulus(32'h1111_1111, 1'b1, 1'b0, 1'b0);
    checkOutput("a_idx1", 128'(bus.word_idx), 128'(1));
    applyStimulus(32'h2222_2222, 1'b1, 1'b0, 1'b0);
    checkOutput("a_idx2", 128'(bus.word_idx), 128'(2));
    checkOutput("a_not_valid_yet", 128'(bus.dout_valid), 128'(0));
    sb_q.push_back(128'h00_0000_00AB_2222_2222_1111_1111);
    applyStimulus(32'hFFFF_FFAB, 1'b1, 1'b0, 1'b0);
    checkOutput("a_idx0", 128'(bus.word_idx), 128'(0));
    checkOutput("a_valid", 128'(bus.dout_valid), 128'(1));
    checkOutput("a_dout", 128'(bus.dout), 128'h00AB_2222_2222_1111_1111);

    // Vector B completes while A is unconsumed -> HOLD
    applyStimulus(32'h3333_3333, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h4444_4444, 1'b1, 1'b0, 1'b0);
    sb_q.push_back(128'h00CD_4444_4444_3333_3333);
    applyStimulus(32'h1234_56CD, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_din_ready", 128'(bus.din_ready), 128'(0));
    checkOutput("hold_dout_a", 128'(bus.dout), 128'h00AB_2222_2222_1111_1111);
    applyStimulus(32'h5555_5555, 1'b1, 1'b1, 1'b0);
    checkOutput("hold_wr_ignored_idx", 128'(bus.word_idx), 128'(0));
    checkOutput("hold_still_blocked", 128'(bus.din_ready), 128'(0));
`ifdef IN_REGISTER_DBUF_OVERRUN_EN
    checkOutput("overrun_set", 128'(overrun), 128'(1));
`endif
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("hold_ack_dout_b", 128'(bus.dout), 128'h00CD_4444_4444_3333_3333);
    checkOutput("hold_ack_valid", 128'(bus.dout_valid), 128'(1));
    checkOutput("hold_ack_ready", 128'(bus.din_ready), 128'(1));
`ifdef IN_REGISTER_DBUF_OVERRUN_EN
    checkOutput("overrun_sticky", 128'(overrun), 128'(1));
`endif
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("ack_clears_valid", 128'(bus.dout_valid), 128'(0));
    checkOutput("ack_keeps_dout", 128'(bus.dout), 128'h00CD_4444_4444_3333_3333);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("ack_idle_no_effect", 128'(bus.dout_valid), 128'(0));

    // Flush discards the partial vector and wins over a same-cycle write
    applyStimulus(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h9999_9999, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_idx", 128'(bus.word_idx), 128'(0));
    applyStimulus(32'h0000_0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0000_0002, 1'b1, 1'b0, 1'b0);
    sb_q.push_back(128'h0003_0000_0002_0000_0001);
    applyStimulus(32'h0000_0003, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_dout", 128'(bus.dout), 128'h0003_0000_0002_0000_0001);

    // Completing write with same-cycle ack replaces dout directly
    applyStimulus(32'h0000_0004, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0000_0005, 1'b1, 1'b0, 1'b0);
    sb_q.push_back(128'h0006_0000_0005_0000_0004);
    applyStimulus(32'h0000_0006, 1'b1, 1'b0, 1'b1);
    checkOutput("ack_wr_valid", 128'(bus.dout_valid), 128'(1));
    checkOutput("ack_wr_ready", 128'(bus.din_ready), 128'(1));
    checkOutput("ack_wr_dout", 128'(bus.dout), 128'h0006_0000_0005_0000_0004);

    // Reset mid-assembly
    applyStimulus(32'hAAAA_AAAA, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'hBBBB_BBBB, 1'b1, 1'b0, 1'b0);
    applyReset();
    checkOutput("mid_rst_dout", 128'(bus.dout), 128'(0));
    checkOutput("mid_rst_valid", 128'(bus.dout_valid), 128'(0));
    checkOutput("mid_rst_idx", 128'(bus.word_idx), 128'(0));
`ifdef IN_REGISTER_DBUF_OVERRUN_EN
    checkOutput("overrun_rst", 128'(overrun), 128'(0));
`endif
    applyStimulus(32'h0000_0007, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0000_0008, 1'b1, 1'b0, 1'b0);
    sb_q.push_back(128'h0009_0000_0008_0000_0007);
    applyStimulus(32'h0000_0009, 1'b1, 1'b0, 1'b0);
    checkOutput("fresh_dout", 128'(bus.dout), 128'h0009_0000_0008_0000_0007);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

    // Single-word instance, 16 bits from a 64-bit bus
    checkOutput("w1_rst_valid", 128'(bus2.dout_valid), 128'(0));
    applyStimulusWide(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
    checkOutput("w1_dout", 128'(bus2.dout), 128'hDEF0);
    checkOutput("w1_valid", 128'(bus2.dout_valid), 128'(1));
    checkOutput("w1_idx", 128'(bus2.word_idx), 128'(0));
    applyStimulusWide(64'h0, 1'b0, 1'b1);
    checkOutput("w1_ack_valid", 128'(bus2.dout_valid), 128'(0));
    applyStimulusWide(64'h0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/in_register_dbuf.md
Name: in_register_dbuf

Overview:
- Parametrised, double-buffered N-bit input register for the accelerator adapter.
- Assembles a C_NUM_BITS-wide argument from successive C_BUS_WIDTH-bit writes.
- Presents each completed vector on a held output with a valid/ack handshake, so the next vector can be assembled while the accelerator still holds the previous one.
- Sits between the AXI-Lite/stream write path and the accelerator scalar-argument port.

Parameters:
- C_NUM_BITS, 72: width of the assembled vector, 1..1024.
- C_BUS_WIDTH, 32: input chunk width, 32 or 64.
- Derived C_NUM_WORDS = ceil(C_NUM_BITS/C_BUS_WIDTH).
- Derived C_UPPER_BITS = C_NUM_BITS - (C_NUM_WORDS-1)*C_BUS_WIDTH.
- Derived C_COUNT_BITS = max(1, ceil(log2(C_NUM_WORDS))).

Ports:
- clk  in  1  rising-edge clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- din  in  C_BUS_WIDTH  input chunk; word 0 is least significant.
- we  in  1  write strobe; a chunk is accepted when we && din_ready.
- din_ready  out  1  block can accept a chunk.
- flush  in  1  discard the partially assembled vector.
- word_idx  out  C_COUNT_BITS  index of the next chunk to be written.
- dout  out  C_NUM_BITS  held output vector.
- dout_valid  out  1  dout holds an unconsumed vector.
- dout_ack  in  1  consumer takes dout this cycle.

Behaviour:
- Storage:
  - Assembly buffer of C_NUM_WORDS*C_BUS_WIDTH bits.
  - Output register of C_NUM_BITS bits.
  - Two-state FSM: FILL and HOLD.
- Reset (rst=1 at an edge):
  - state=FILL, word_idx=0, dout=0, dout_valid=0, assembly buffer cleared.
  - din_ready is combinational: 1 in FILL, 0 in HOLD; it is 1 in the first cycle after reset.
  - Reset mid-assembly discards partial data.
- FILL, accepted non-last chunk:
  - Buffer word[word_idx] <= din.
  - word_idx increments.
- FILL, accepted last chunk (word_idx==C_NUM_WORDS-1):
  - Only din[C_UPPER_BITS-1:0] is used; the remaining upper bits are ignored and never reach dout.
  - word_idx <= 0.
  - If dout_valid==0, or dout_ack==1 in the same cycle:
    - dout <= {last chunk, buffer lower words}, dout_valid <= 1.
    - Stay in FILL.
    - Latency: vector visible the cycle after the last write edge.
  - Otherwise: the last chunk is stored into the buffer, state <= HOLD.
- HOLD:
  - din_ready=0; writes are ignored and the buffer is unchanged.
  - On dout_ack: dout <= buffer, dout_valid stays 1, state <= FILL, din_ready=1 the next cycle.
- Acknowledge:
  - dout_ack with dout_valid==1 in FILL and no completing write: dout_valid <= 0, dout unchanged.
  - dout_ack while dout_valid==0 has no effect.
- flush:
  - In FILL: word_idx <= 0 and any write in the same cycle is discarded (flush wins).
  - In HOLD: ignored; the completed vector is not discarded.
  - Never affects dout or dout_valid.
- C_NUM_WORDS==1: every accepted write completes a vector; word_idx is held at 0.
- Throughput: one chunk per cycle sustained, provided the consumer acks each vector before the next one completes.

Optional Feature:
- Macro IN_REGISTER_DBUF_OVERRUN_EN.
- When defined:
  - Adds output overrun (1 bit), a sticky flag set at any edge where we==1 && din_ready==0.
  - Cleared only by rst.
  - The dropped chunk is still discarded.
- When undefined: no overrun port and no extra logic; writes while din_ready==0 are silently ignored.

Test Plan:
- Defaults (72/32), writes 0x11111111, 0x22222222, 0xFFFFFFAB on consecutive cycles, no ack -> dout=0xAB_22222222_11111111, dout_valid=1 one cycle after the third write, word_idx 0,1,2,0.
- Complete vector A (dout_valid=1, not acked), write three chunks of vector B -> state HOLD, din_ready=0, dout still A. Then pulse dout_ack -> dout=B next cycle, dout_valid stays 1, din_ready=1.
- Write word 0 = 0xDEADBEEF, then flush, then three new chunks 1,2,3 -> dout=0x03_00000002_00000001. The 0xDEADBEEF chunk never appears.
- Assert rst after two chunks -> dout=0, dout_valid=0, word_idx=0. The next three chunks form a complete fresh vector.
- C_NUM_BITS=16, C_BUS_WIDTH=64, single write 0x123456789ABCDEF0 -> dout=0xDEF0, dout_valid=1 next cycle. Then ack with no write -> dout_valid=0.
- With IN_REGISTER_DBUF_OVERRUN_EN defined: write while in HOLD -> overrun=1 and stays 1 after ack, cleared only by rst. Without the macro: the same write is ignored with no side effect.
